m_msg_ram: RTL and testbench
============================

# m_msg_ram

Parametrised message memory for the UART datapath: a 1-write/1-read RAM with registered reads, a request/valid read handshake, and a hardware init sweep that loads either zeros or the boot banner "Hello, UART\r\n". It replaces the single-cycle-clear 8-bit × 1024 memory. The UART transmit sequencer reads from it; the receive path or host logic writes to it. It also tracks the current message length so the transmitter knows where to stop.

## Interface
- DATA_W, 8: data width in bits; must be ≥ 8 (banner bytes zero-extended).
- ADDR_W, 10: address width; DEPTH = 2**ADDR_W; must be ≥ 4.
- INIT_MODE, 1: 0 = sweep writes zeros; 1 = sweep writes banner at addresses 0..12, zeros elsewhere.

- CLK  in  1  clock (100 MHz).
- RST_N  in  1  reset; asynchronous assert, active-low.
- CLR  in  1  start (or restart) the init sweep.
- BUSY  out  1  init sweep in progress; reads and writes ignored.
- RREQ  in  1  read request.
- RADDR  in  ADDR_W  read address, sampled with RREQ.
- RVALID  out  1  RDATA valid; one-cycle pulse per accepted request.
- RDATA  out  DATA_W  registered read data.
- WE  in  1  write enable.
- WADDR  in  ADDR_W  write address.
- WDATA  in  DATA_W  write data.
- LEN  out  ADDR_W+1  message length = highest written address + 1.
- DROP  out  1  one-cycle pulse: RREQ or WE was ignored this cycle.

## Operation
- Reset (RST_N low, asynchronous): BUSY=1, sweep pointer=0, RVALID=0, RDATA=0, LEN=0, DROP=0. The array is not reset; the sweep rewrites it.
- Sweep:
  - Starts on the first rising edge after RST_N rises, or on the edge after CLR=1.
  - Writes one address per cycle, 0 to DEPTH-1 ascending.
  - Written value is the banner byte for that address (INIT_MODE=1, addr ≤ 12), else 0.
  - The edge that writes DEPTH-1 clears BUSY and sets LEN: 13 if INIT_MODE=1, else 0.
- CLR during a sweep restarts it at address 0. CLR also sets BUSY=1 and LEN=0 on the same edge.
- Reads:
  - Accepted when RREQ=1 and BUSY=0 at an edge.
  - RDATA=mem[RADDR] and RVALID=1 on that edge.
  - Back-to-back requests are allowed, one per cycle.
  - With no accepted request, RVALID=0 and RDATA holds its last value.
- Writes:
  - Accepted when WE=1, BUSY=0 and CLR=0.
  - An accepted write sets mem[WADDR]=WDATA and LEN=max(LEN, WADDR+1).
  - LEN never decreases except via CLR or reset.
- Read/write collision (same edge, same address): read-first; RDATA returns the old contents.
- Ignored requests:
  - RREQ or WE while BUSY=1, or WE together with CLR, is dropped.
  - DROP pulses on the following edge. The memory, LEN and RVALID are unaffected.
- Arithmetic: WADDR+1 is computed in ADDR_W+1 bits, so a write to DEPTH-1 gives LEN=DEPTH with no wrap.

## Timing
- Read latency: 1 cycle. RREQ sampled at edge t gives RVALID/RDATA valid after edge t, usable at t+1.
- Write-to-read: a write at edge t is visible to a read accepted at edge t+1.
- Sweep from reset: BUSY high for exactly DEPTH edges after RST_N deassertion (1024 for defaults).
- Sweep from CLR: CLR at edge t gives BUSY=1 from t, and BUSY falls at edge t+DEPTH. A CLR at edge t+k restarts this count.
- Reset mid-sweep or mid-read: all outputs return immediately to their reset values, and the pending RVALID is lost.
- LEN updates on the same edge as the accepted write.
- DROP is registered: it is high during the cycle after the dropped request.

## Test plan
- Reset release, INIT_MODE=1, defaults → BUSY=1 for 1024 cycles, then LEN=13. Reads of 0..12 return 48 65 6c 6c 6f 2c 20 55 41 52 54 0d 0a; read of 13 returns 00; each RVALID appears 1 cycle after its RREQ.
- After the sweep, write 0x5A to addr 20, then read addr 20 on the next cycle → RDATA=0x5A, LEN=21. A further write to addr 5 leaves LEN=21.
- Same-cycle WE/RREQ to addr 3 (old 0x6c, new 0x33) → RDATA=0x6c; the next read returns 0x33.
- CLR pulse, then RREQ and WE at sweep cycle 100 → DROP pulses twice, no RVALID, LEN=0. A CLR at cycle 500 restarts the sweep and BUSY falls 1024 cycles after it. Memory afterwards matches the banner, with addr 20 = 0.
- RST_N asserted mid-way through a 4-deep back-to-back read burst → RVALID=0 and RDATA=0 immediately. After release, reads are dropped until BUSY=0.
- INIT_MODE=0, ADDR_W=4 → BUSY for 16 cycles, all reads return 0, LEN=0. A write to addr 15 gives LEN=16.

Source files
------------

// File: rtl/m_msg_ram.sv
// Message memory for the UART datapath: 1W/1R RAM with registered reads,
// a hardware init sweep (zeros or boot banner) and message-length tracking.
module m_msg_ram #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 10,
  parameter int INIT_MODE = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CLR,
  output logic              BUSY,
  input  logic              RREQ,
  input  logic [ADDR_W-1:0] RADDR,
  output logic              RVALID,
  output logic [DATA_W-1:0] RDATA,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic [DATA_W-1:0] WDATA,
  output logic [ADDR_W:0]   LEN,
  output logic              DROP
);

  localparam int DEPTH = 1 << ADDR_W;

  // Two-state controller; BUSY is the direct decode of the state register.
  localparam logic [0:0] ST_SWEEP = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam logic [ADDR_W:0] BANNER_LEN = (INIT_MODE == 1) ? (ADDR_W+1)'(13) : '0;

  logic [0:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              rd_acc;
  logic              wr_acc;
  logic              sweep_we;
  logic [ADDR_W:0]   wr_end;
  logic [DATA_W-1:0] sweep_data;

  function automatic logic [7:0] banner_byte(input logic [ADDR_W-1:0] a);
    logic [7:0] b;
    b = 8'h00;
    if (a <= ADDR_W'(12)) begin
      case (a[3:0])
        4'd0:    b = 8'h48;
        4'd1:    b = 8'h65;
        4'd2:    b = 8'h6c;
        4'd3:    b = 8'h6c;
        4'd4:    b = 8'h6f;
        4'd5:    b = 8'h2c;
        4'd6:    b = 8'h20;
        4'd7:    b = 8'h55;
        4'd8:    b = 8'h41;
        4'd9:    b = 8'h52;
        4'd10:   b = 8'h54;
        4'd11:   b = 8'h0d;
        4'd12:   b = 8'h0a;
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

  // Read handshake: RREQ is accepted at any edge where BUSY is low; the
  // following cycle carries RVALID=1 with RDATA, one pulse per acceptance.
  // There is no backpressure. Writes are fire-and-forget under the same gate.
  assign BUSY       = (state == ST_SWEEP);
  assign rd_acc     = RREQ && !BUSY;
  assign wr_acc     = WE && !BUSY && !CLR;
  assign sweep_we   = BUSY && !CLR;
  assign wr_end     = {1'b0, WADDR} + (ADDR_W+1)'(1);
  assign sweep_data = (INIT_MODE == 1) ? DATA_W'(banner_byte(ptr)) : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= ST_SWEEP;
      ptr    <= '0;
      RVALID <= 1'b0;
      RDATA  <= '0;
      LEN    <= '0;
      DROP   <= 1'b0;
    end else begin
      DROP   <= (RREQ && BUSY) || (WE && (BUSY || CLR));
      RVALID <= rd_acc;
      if (rd_acc) RDATA <= mem[RADDR];
      if (CLR) begin
        state <= ST_SWEEP;
        ptr   <= '0;
        LEN   <= '0;
      end else if (state == ST_SWEEP) begin
        ptr <= ptr + ADDR_W'(1);
        if (ptr == '1) begin
          state <= ST_RUN;
          LEN   <= BANNER_LEN;
        end
      end else if (wr_acc && (wr_end > LEN)) begin
        LEN <= wr_end;
      end
    end
  end

  // Array has no reset; the sweep owns the write port while BUSY.
  // The read above uses the pre-edge contents, giving read-first collisions.
  always_ff @(posedge CLK) begin
    if (sweep_we) mem[ptr] <= sweep_data;
    else if (wr_acc) mem[WADDR] <= WDATA;
  end

endmodule

// File: tb/tb_m_msg_ram.sv
// Directed bench for m_msg_ram: banner sweep, reads/writes, collisions,
// CLR restarts, mid-burst reset, and a small zero-init instance.
module tb_m_msg_ram;

  logic        clk;
  logic        rst_n, clr, rreq, we;
  logic [9:0]  raddr, waddr;
  logic [7:0]  wdata, rdata;
  logic        busy, rvalid, drop;
  logic [10:0] len;

  logic        s_rst_n, s_clr, s_rreq, s_we;
  logic [3:0]  s_raddr, s_waddr;
  logic [7:0]  s_wdata, s_rdata;
  logic        s_busy, s_rvalid, s_drop;
  logic [4:0]  s_len;

  int n_checks = 0;
  int n_errors = 0;
  int cnt, nvalid;
  logic [7:0] banner [0:12];

  m_msg_ram #(.DATA_W(8), .ADDR_W(10), .INIT_MODE(1)) dut (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .BUSY(busy),
    .RREQ(rreq), .RADDR(raddr), .RVALID(rvalid), .RDATA(rdata),
    .WE(we), .WADDR(waddr), .WDATA(wdata), .LEN(len), .DROP(drop)
  );

  m_msg_ram #(.DATA_W(8), .ADDR_W(4), .INIT_MODE(0)) dut_small (
    .CLK(clk), .RST_N(s_rst_n), .CLR(s_clr), .BUSY(s_busy),
    .RREQ(s_rreq), .RADDR(s_raddr), .RVALID(s_rvalid), .RDATA(s_rdata),
    .WE(s_we), .WADDR(s_waddr), .WDATA(s_wdata), .LEN(s_len), .DROP(s_drop)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    banner = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h2c, 8'h20,
               8'h55, 8'h41, 8'h52, 8'h54, 8'h0d, 8'h0a};
    rst_n = 1'b0; clr = 1'b0; rreq = 1'b0; we = 1'b0;
    raddr = '0; waddr = '0; wdata = '0;
    s_rst_n = 1'b0; s_clr = 1'b0; s_rreq = 1'b0; s_we = 1'b0;
    s_raddr = '0; s_waddr = '0; s_wdata = '0;
    repeat (3) step();

    check("rst_busy", busy, 1);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_len", len, 0);
    check("rst_drop", drop, 0);

    // sweep after reset release
    rst_n = 1'b1;
    cnt = 0;
    while (busy && cnt < 2000) begin step(); cnt++; end
    check("sweep_cycles_reset", cnt, 1024);
    check("len_after_sweep", len, 13);

    // back-to-back banner reads, 0..13
    for (int i = 0; i < 14; i++) begin
      rreq = 1'b1; raddr = 10'(i);
      step();
      check($sformatf("banner_rvalid_%0d", i), rvalid, 1);
      check($sformatf("banner_rdata_%0d", i), rdata, (i < 13) ? banner[i] : 8'h00);
    end
    rreq = 1'b0;
    step();
    check("idle_rvalid", rvalid, 0);

    // write then read, LEN tracking
    we = 1'b1; waddr = 10'd20; wdata = 8'h5a;
    step();
    we = 1'b0;
    check("len_after_w20", len, 21);
    rreq = 1'b1; raddr = 10'd20;
    step();
    rreq = 1'b0;
    check("w20_rvalid", rvalid, 1);
    check("w20_rdata", rdata, 8'h5a);
    step();
    check("rdata_hold", rdata, 8'h5a);
    we = 1'b1; waddr = 10'd5; wdata = 8'h2c;
    step();
    we = 1'b0;
    check("len_no_decrease", len, 21);

    // read-first collision
    we = 1'b1; waddr = 10'd3; wdata = 8'h33; rreq = 1'b1; raddr = 10'd3;
    step();
    we = 1'b0;
    check("coll_old", rdata, 8'h6c);
    step();
    rreq = 1'b0;
    check("coll_new", rdata, 8'h33);

    // CLR, dropped requests, restart at sweep cycle 500
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_busy", busy, 1);
    check("clr_len", len, 0);
    repeat (99) step();
    rreq = 1'b1; raddr = 10'd0;
    step();
    rreq = 1'b0;
    check("drop_rreq", drop, 1);
    check("drop_no_rvalid", rvalid, 0);
    step();
    check("drop_one_cycle", drop, 0);
    we = 1'b1; waddr = 10'd7; wdata = 8'hff;
    step();
    we = 1'b0;
    check("drop_we", drop, 1);
    check("drop_len", len, 0);
    repeat (397) step();
    clr = 1'b1; we = 1'b1; waddr = 10'd20; wdata = 8'h77;
    step();
    clr = 1'b0; we = 1'b0;
    check("drop_we_clr", drop, 1);
    check("reclr_busy", busy, 1);
    cnt = 0;
    while (busy && cnt < 2000) begin step(); cnt++; end
    check("sweep_cycles_clr", cnt, 1024);
    check("len_after_reclr", len, 13);
    for (int i = 0; i < 13; i++) begin
      rreq = 1'b1; raddr = 10'(i);
      step();
      check($sformatf("reclr_rdata_%0d", i), rdata, banner[i]);
    end
    raddr = 10'd20;
    step();
    rreq = 1'b0;
    check("reclr_addr20", rdata, 0);

    // reset in the middle of a read burst
    rreq = 1'b1; raddr = 10'd0;
    step();
    check("burst_rvalid0", rvalid, 1);
    raddr = 10'd1;
    step();
    check("burst_rdata1", rdata, 8'h65);
    raddr = 10'd2;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rvalid", rvalid, 0);
    check("midrst_rdata", rdata, 0);
    check("midrst_busy", busy, 1);
    check("midrst_len", len, 0);
    step();
    rst_n = 1'b1;
    step();
    cnt = 1;
    check("post_rst_drop", drop, 1);
    check("post_rst_rvalid", rvalid, 0);
    nvalid = 0;
    while (busy && cnt < 2000) begin
      step(); cnt++;
      if (rvalid) nvalid++;
    end
    check("sweep_cycles_rst2", cnt, 1024);
    check("no_rvalid_while_busy", nvalid, 0);
    step();
    rreq = 1'b0;
    check("first_read_after", rvalid, 1);
    check("first_rdata_after", rdata, 8'h6c);

    // small zero-init instance
    s_rst_n = 1'b1;
    cnt = 0;
    while (s_busy && cnt < 100) begin step(); cnt++; end
    check("s_sweep_cycles", cnt, 16);
    check("s_len", s_len, 0);
    for (int i = 0; i < 16; i++) begin
      s_rreq = 1'b1; s_raddr = 4'(i);
      step();
      check($sformatf("s_rdata_%0d", i), {s_rvalid, s_rdata}, 9'h100);
    end
    s_rreq = 1'b0;
    s_we = 1'b1; s_waddr = 4'd15; s_wdata = 8'ha5;
    step();
    s_we = 1'b0;
    check("s_len_full", s_len, 16);
    s_rreq = 1'b1; s_raddr = 4'd15;
    step();
    s_rreq = 1'b0;
    check("s_rdata_15", s_rdata, 8'ha5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
